// File: rtl/core_pkg.sv
// Shared constants and types for the 16-bit pipelined core.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package core_pkg;

  // Datapath/address width and register-specifier width.
  localparam int DW = 16;
  localparam int RW = 3;

  // Halt tracking in the memory stage: RUN until a halting instruction
  // has been seen there, then HALTED until reset.
  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } halt_state_t;

endpackage

// File: rtl/ex_mem_if.sv
// Execute-to-memory boundary bundle: ex_* inputs, hazard controls, writeback snoop, mem_* outputs.
// Latency: n/a (wires only).
// Backpressure: stall/flush from the hazard unit travel in this bundle.
interface ex_mem_if #(
  parameter int DW = core_pkg::DW,
  parameter int RW = core_pkg::RW
);
  // Execute-stage side
  logic          ex_valid;
  logic [DW-1:0] ex_alu_out;
  logic [DW-1:0] ex_wr_data;
  logic [RW-1:0] ex_st_reg;
  logic          ex_mem_rd;
  logic          ex_mem_wr;
  logic          ex_reg_wr;
  logic          ex_halt;
  logic [RW-1:0] ex_wr_reg;

  // Hazard unit controls
  logic          stall;
  logic          flush;

  // Writeback snoop for store-data forwarding
  logic          wb_reg_wr;
  logic [RW-1:0] wb_wr_reg;
  logic [DW-1:0] wb_data;

  // Memory-stage side
  logic          mem_valid;
  logic          mem_rd;
  logic          mem_wr;
  logic          mem_reg_wr;
  logic          mem_halt;
  logic [DW-1:0] mem_alu_out;
  logic [DW-1:0] mem_wr_data;
  logic [RW-1:0] mem_wr_reg;
  logic          dump;

  // Driver of the execute stage / hazard unit / writeback
  modport master (
    output ex_valid, ex_alu_out, ex_wr_data, ex_st_reg,
           ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_halt, ex_wr_reg,
           stall, flush, wb_reg_wr, wb_wr_reg, wb_data,
    input  mem_valid, mem_rd, mem_wr, mem_reg_wr, mem_halt,
           mem_alu_out, mem_wr_data, mem_wr_reg, dump
  );

  // The pipeline latch itself
  modport slave (
    input  ex_valid, ex_alu_out, ex_wr_data, ex_st_reg,
           ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_halt, ex_wr_reg,
           stall, flush, wb_reg_wr, wb_wr_reg, wb_data,
    output mem_valid, mem_rd, mem_wr, mem_reg_wr, mem_halt,
           mem_alu_out, mem_wr_data, mem_wr_reg, dump
  );

endinterface

// File: rtl/ex_mem_latch_pipe_reg.sv
// Width-parameterised pipeline register: rst -> 0, flush -> flush_val, hold -> keep, else load d.
// Latency: one cycle from d to q.
// Backpressure: hold freezes the contents; flush overrides hold.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         hold,
  input  logic [W-1:0] flush_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Priority register update: reset, then flush value, then hold, then load.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (flush) begin
      q <= flush_val;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline latch with halt tracking (one-shot dump); optional WB->MEM store-data forwarding under EX_MEM_FWD_EN.
// Latency: one cycle ex_* -> mem_*; dump is decoded from registered state only.
// Backpressure: stall holds the contents (forwarding may still refresh store data), flush inserts a bubble.
module ex_mem_latch #(
  parameter int DW = core_pkg::DW,
  parameter int RW = core_pkg::RW
) (
  input logic      clk,
  input logic      rst,
  ex_mem_if.slave  bus
);
  import core_pkg::*;

  halt_state_t   state;
  logic          halted;
  logic          cap_ok;
  logic [4:0]    ctl_d;
  logic [4:0]    ctl_q;
  logic [DW-1:0] alu_q;
  logic [RW-1:0] wr_reg_q;
  logic [DW-1:0] wr_data_d;
  logic [DW-1:0] wr_data_q;
  logic          wr_data_hold;
  logic          fwd_cap;
  logic          fwd_hold;

  assign halted = (state == HALTED);

  // After a halt has reached this stage, every new capture is a bubble.
  assign cap_ok = bus.ex_valid & ~halted;

  // Control bits are qualified with valid on the way in, so an invalid slot
  // never carries an active control bit.
  assign ctl_d = {cap_ok,
                  bus.ex_mem_rd & cap_ok,
                  bus.ex_mem_wr & cap_ok,
                  bus.ex_reg_wr & cap_ok,
                  bus.ex_halt   & cap_ok};

  // Control group: flush clears to a bubble.
  pipe_reg #(.W(5)) u_ctl (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .hold      (bus.stall),
    .flush_val (5'b0),
    .d         (ctl_d),
    .q         (ctl_q)
  );

  // Address/destination group: a flush leaves the data as is since valid is cleared.
  pipe_reg #(.W(DW)) u_alu (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .hold      (bus.stall),
    .flush_val (alu_q),
    .d         (bus.ex_alu_out),
    .q         (alu_q)
  );

  pipe_reg #(.W(RW)) u_wr_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .hold      (bus.stall),
    .flush_val (wr_reg_q),
    .d         (bus.ex_wr_reg),
    .q         (wr_reg_q)
  );

`ifdef EX_MEM_FWD_EN
  logic [RW-1:0] st_reg_q;

  // Source register of the held store, kept so a late writeback can still be forwarded.
  pipe_reg #(.W(RW)) u_st_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .hold      (bus.stall),
    .flush_val (st_reg_q),
    .d         (bus.ex_st_reg),
    .q         (st_reg_q)
  );

  // Load directly followed by a dependent store: take the value being written back.
  assign fwd_cap  = bus.ex_mem_wr & bus.wb_reg_wr & (bus.wb_wr_reg == bus.ex_st_reg);
  // mem_wr is already valid-qualified, so this only fires for a real held store.
  assign fwd_hold = bus.mem_wr & bus.wb_reg_wr & (bus.wb_wr_reg == st_reg_q);
`else
  logic unused_fwd;

  // Without forwarding the hazard unit stalls load->store pairs; wb_* and st_reg are not needed.
  assign fwd_cap    = 1'b0;
  assign fwd_hold   = 1'b0;
  assign unused_fwd = ^{bus.ex_st_reg, bus.wb_reg_wr, bus.wb_wr_reg, bus.wb_data};
`endif

  // While stalled the only new value store data can take is the writeback value.
  assign wr_data_d    = (bus.stall | fwd_cap) ? bus.wb_data : bus.ex_wr_data;
  assign wr_data_hold = bus.stall & ~fwd_hold;

  pipe_reg #(.W(DW)) u_wr_data (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .hold      (wr_data_hold),
    .flush_val (wr_data_q),
    .d         (wr_data_d),
    .q         (wr_data_q)
  );

  // Halt FSM: leave RUN the cycle after a valid halt is registered; only reset returns to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else if (state == RUN && ctl_q[4] && ctl_q[0]) begin
      state <= HALTED;
    end
  end

  assign bus.mem_valid   = ctl_q[4];
  assign bus.mem_rd      = ctl_q[3];
  assign bus.mem_wr      = ctl_q[2];
  assign bus.mem_reg_wr  = ctl_q[1];
  assign bus.mem_halt    = ctl_q[0];
  assign bus.mem_alu_out = alu_q;
  assign bus.mem_wr_data = wr_data_q;
  assign bus.mem_wr_reg  = wr_reg_q;

  // Single pulse: a stalled halt sees HALTED from its second cycle on; flush cannot reach this term.
  assign bus.dump = (state == RUN) & ctl_q[4] & ctl_q[0];

endmodule

// File: doc/ex_mem_latch.md
# ex_mem_latch

Pipeline register between the execute stage and the data-memory stage of the 16-bit pipelined core. Captures the ALU result, store data and control bits each cycle, honours stall and flush from the hazard unit, and raises the one-shot `dump` when a halting instruction reaches the memory stage. An optional writeback-to-memory forwarding path corrects store data for a load immediately followed by a dependent store.

## Interface
Parameters:
- `DW`, 16, data and address width
- `RW`, 3, register-specifier width

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `ex_valid`  in  1  execute stage holds a real instruction
- `ex_alu_out`  in  DW  ALU result or effective address
- `ex_wr_data`  in  DW  store data read in decode
- `ex_st_reg`  in  RW  source register of the store data
- `ex_mem_rd`, `ex_mem_wr`, `ex_reg_wr`, `ex_halt`  in  1 each  control bits
- `ex_wr_reg`  in  RW  destination register
- `stall`  in  1  hold the current contents
- `flush`  in  1  replace the contents with a bubble
- `wb_reg_wr`  in  1  writeback is writing the register file
- `wb_wr_reg`  in  RW  writeback destination
- `wb_data`  in  DW  writeback value
- `mem_valid`, `mem_rd`, `mem_wr`, `mem_reg_wr`, `mem_halt`  out  1 each  registered controls; `mem_rd`, `mem_wr` and `mem_reg_wr` are already ANDed with valid
- `mem_alu_out`, `mem_wr_data`  out  DW  registered address and store data
- `mem_wr_reg`  out  RW  registered destination
- `dump`  out  1  one-cycle memory-dump request

## Operation
- Update priority each cycle: `rst` > `flush` > `stall` > capture.
- Capture: all `mem_*` registers load from the `ex_*` inputs. `mem_valid` loads `ex_valid`.
- Stall: every register holds its value. The only change allowed is store-data forwarding (see Configuration).
- Flush: `mem_valid`, `mem_rd`, `mem_wr`, `mem_reg_wr` and `mem_halt` go to 0. Data registers may hold their old value.
- Control outputs are never 1 while `mem_valid` = 0.
- Halt FSM, two states:
  - RUN → HALTED when `mem_valid & mem_halt` is registered.
  - `dump` = 1 only in RUN with `mem_valid & mem_halt`. This gives a single pulse, even if a stall holds the halt.
  - In HALTED, new captures load as bubbles, and `dump` stays 0 until `rst`.
  - A flush arriving in the same cycle that `dump` fires does not cancel the dump.
- Reset values: all outputs 0, FSM in RUN.
- A reset mid-stall or mid-halt discards all contents.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on `mem_*` after edge N.
- `dump` is combinational from state and registers, with no input-to-output combinational path.
- `stall` and `flush` take effect at the same edge they are sampled.
- Forwarding compares `wb_*` inputs in the same cycle, so they must be stable before the edge.

## Configuration
- `EX_MEM_FWD_EN` defined: store-data forwarding from writeback is compiled in.
  - On capture: if `ex_mem_wr & wb_reg_wr & (wb_wr_reg == ex_st_reg)`, then `mem_wr_data` loads `wb_data` instead of `ex_wr_data`.
  - On stall: if the held instruction is a valid store and `wb_reg_wr & (wb_wr_reg == held st_reg)`, then `mem_wr_data` updates to `wb_data`.
  - The latch keeps an internal `st_reg` register for this comparison.
- `EX_MEM_FWD_EN` not defined: `mem_wr_data` always loads `ex_wr_data` and is frozen while stalled. There is no `st_reg` register and the `wb_*` ports are ignored. The hazard unit must then stall load→store pairs instead.

## Structure
- Shared package `core_pkg`: `DW` and `RW` constants, and a `halt_state_t` enum with members RUN and HALTED.
- One sub-module, `pipe_reg`: a width-parameterised register with priority rst / flush-value / hold / load. It is instantiated for each field group.
- FSM and forwarding logic stay in the top level.

## Test plan
- Reset with `ex_valid` = 1 and all inputs nonzero → every output is 0 and `dump` is 0.
- Capture a store: `ex_alu_out` = 0x1234, `ex_wr_data` = 0xBEEF, `ex_mem_wr` = 1 → next cycle `mem_wr` = 1, `mem_alu_out` = 0x1234, `mem_wr_data` = 0xBEEF.
- Stall for 3 cycles while `ex_*` changes → outputs are unchanged. Then `flush` with `stall` also high → `mem_valid`, `mem_wr` and `mem_reg_wr` go to 0.
- Halt enters, then stall for 2 cycles → `dump` is high for exactly 1 cycle. A following valid load captures as a bubble with `mem_rd` = 0. `rst` restores RUN.
- With `EX_MEM_FWD_EN`: store with `ex_st_reg` = 3, `ex_wr_data` = 0x0000, and `wb_reg_wr` = 1, `wb_wr_reg` = 3, `wb_data` = 0x5A5A in the same cycle → `mem_wr_data` = 0x5A5A. Without the macro → 0x0000.
- With `EX_MEM_FWD_EN`: store held by stall, then writeback to r3 with 0x00FF → `mem_wr_data` becomes 0x00FF. A writeback to r4 instead leaves it unchanged.
